// File: rtl/rv32_bil_exec_unit.sv
// RV32I helper datapath for branch, register-immediate ALU and load opcodes,
// with a sticky illegal-encoding flag and a taken-branch counter. RV_BIL_MISALIGN_CHK_EN enables misaligned-load trapping.
module rv32_bil_exec_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  idata,
    input  logic [XLEN-1:0]  iaddr,
    input  logic [XLEN-1:0]  rv1,
    input  logic [XLEN-1:0]  rv2,
    input  logic [XLEN-1:0]  drdata,
    input  logic             err_clr,
    output logic [XLEN-1:0]  daddr,
    output logic [XLEN-1:0]  regdata_I,
    output logic [XLEN-1:0]  regdata_L,
    output logic [XLEN-1:0]  iaddr_val,
    output logic             br_taken,
    output logic             err,
    output logic [CNT_W-1:0] br_cnt
);

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_B = 7'b1100011;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      funct7;
    logic [4:0]      shamt;
    logic            is_i;
    logic            is_l;
    logic            is_b;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_b;

    assign opcode = idata[6:0];
    assign f3     = idata[14:12];
    assign funct7 = idata[31:25];
    assign shamt  = idata[24:20];
    assign is_i   = (opcode == OP_I);
    assign is_l   = (opcode == OP_L);
    assign is_b   = (opcode == OP_B);

    assign imm_i = {{(XLEN-12){idata[31]}}, idata[31:20]};
    assign imm_b = {{(XLEN-13){idata[31]}}, idata[31], idata[7], idata[30:25], idata[11:8], 1'b0};

    // Register source fields are resolved by the core; only the immediate bits matter here.
    logic unused_rs_fields;
    assign unused_rs_fields = ^idata[19:15];

    // ------------------------------------------------------------------
    // Register-immediate ALU (evaluated every cycle)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] sra_res;

    assign sra_res = XLEN'($signed(rv1) >>> shamt);

    always_comb begin
        alu_res = '0;
        case (f3)
            3'b000:  alu_res = rv1 + imm_i;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rv1) < $signed(imm_i))};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, (rv1 < imm_i)};
            3'b100:  alu_res = rv1 ^ imm_i;
            3'b110:  alu_res = rv1 | imm_i;
            3'b111:  alu_res = rv1 & imm_i;
            3'b001:  alu_res = rv1 << shamt;
            3'b101:  alu_res = idata[30] ? sra_res : (rv1 >> shamt);
            default: alu_res = '0;
        endcase
    end

    assign regdata_I = alu_res;

    // ------------------------------------------------------------------
    // Load address and data extraction
    // ------------------------------------------------------------------
    logic [7:0]      byte_lane [4];
    logic [15:0]     half_lane [2];
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic            load_misaligned;
    logic [XLEN-1:0] load_res;

    assign daddr = rv1 + imm_i;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lane[gi] = drdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_lane[gi] = drdata[16*gi +: 16];
        end
    endgenerate

    assign sel_byte = byte_lane[daddr[1:0]];
    assign sel_half = half_lane[daddr[1]];

`ifdef RV_BIL_MISALIGN_CHK_EN
    assign load_misaligned = is_l &&
                             ((((f3 == 3'b001) || (f3 == 3'b101)) && daddr[0]) ||
                              ((f3 == 3'b010) && (daddr[1:0] != 2'b00)));
`else
    assign load_misaligned = 1'b0;
`endif

    always_comb begin
        load_res = '0;
        case (f3)
            3'b000:  load_res = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            3'b001:  load_res = {{(XLEN-16){sel_half[15]}}, sel_half};
            3'b010:  load_res = drdata;
            3'b100:  load_res = {{(XLEN-8){1'b0}}, sel_byte};
            3'b101:  load_res = {{(XLEN-16){1'b0}}, sel_half};
            default: load_res = '0;
        endcase
        if (load_misaligned) begin
            load_res = '0;
        end
    end

    assign regdata_L = load_res;

    // ------------------------------------------------------------------
    // Branch compare and next PC
    // ------------------------------------------------------------------
    logic br_eq;
    logic br_lt_s;
    logic br_lt_u;
    logic br_cond;

    assign br_eq   = (rv1 == rv2);
    assign br_lt_s = ($signed(rv1) < $signed(rv2));
    assign br_lt_u = (rv1 < rv2);

    always_comb begin
        br_cond = 1'b0;
        case (f3)
            3'b000:  br_cond = br_eq;
            3'b001:  br_cond = !br_eq;
            3'b100:  br_cond = br_lt_s;
            3'b101:  br_cond = !br_lt_s;
            3'b110:  br_cond = br_lt_u;
            3'b111:  br_cond = !br_lt_u;
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken  = is_b && br_cond;
    assign iaddr_val = br_taken ? (iaddr + imm_b) : (iaddr + XLEN'(4));

    // ------------------------------------------------------------------
    // Illegal-encoding detection
    // ------------------------------------------------------------------
    logic ill_i;
    logic ill_l;
    logic ill_b;
    logic illegal;

    assign ill_i = is_i &&
                   (((f3 == 3'b001) && (funct7 != 7'b0000000)) ||
                    ((f3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000)));
    assign ill_l = is_l && ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
    assign ill_b = is_b && ((f3 == 3'b010) || (f3 == 3'b011));

    assign illegal = ill_i || ill_l || ill_b || load_misaligned;

    // ------------------------------------------------------------------
    // Status registers
    // ------------------------------------------------------------------
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] br_cnt_d;

    always_comb begin
        err_d = err_q;
        // A clear request takes priority over a fault seen in the same cycle.
        if (err_clr) begin
            err_d = 1'b0;
        end else if (illegal) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        br_cnt_d = br_cnt_q;
        if (br_taken) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q    <= 1'b0;
            br_cnt_q <= '0;
        end else begin
            err_q    <= err_d;
            br_cnt_q <= br_cnt_d;
        end
    end

    assign err    = err_q;
    assign br_cnt = br_cnt_q;

endmodule

// File: tb/tb_rv32_bil_exec_unit.sv
// Self-checking bench for rv32_bil_exec_unit: directed cases from the test plan
// followed by randomized instructions checked against an arithmetic reference model.
module tb_rv32_bil_exec_unit;

    logic        clk;
    logic        reset;
    logic [31:0] idata;
    logic [31:0] iaddr;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic [31:0] drdata;
    logic        err_clr;
    logic [31:0] daddr;
    logic [31:0] regdata_I;
    logic [31:0] regdata_L;
    logic [31:0] iaddr_val;
    logic        br_taken;
    logic        err;
    logic [15:0] br_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic        m_err;
    logic [15:0] m_cnt;

    rv32_bil_exec_unit #(.XLEN(32), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .idata     (idata),
        .iaddr     (iaddr),
        .rv1       (rv1),
        .rv2       (rv2),
        .drdata    (drdata),
        .err_clr   (err_clr),
        .daddr     (daddr),
        .regdata_I (regdata_I),
        .regdata_L (regdata_L),
        .iaddr_val (iaddr_val),
        .br_taken  (br_taken),
        .err       (err),
        .br_cnt    (br_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int imm12(input logic [31:0] ins);
        logic signed [11:0] v;
        v = ins[31:20];
        return int'(v);
    endfunction

    function automatic int immb(input logic [31:0] ins);
        logic signed [12:0] v;
        v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return int'(v);
    endfunction

    function automatic logic [31:0] m_daddr(input logic [31:0] ins, input logic [31:0] a);
        return a + imm12(ins);
    endfunction

    function automatic logic m_misaligned(input logic [31:0] ins, input logic [31:0] a);
`ifdef RV_BIL_MISALIGN_CHK_EN
        logic [31:0] ad;
        int sz;
        ad = m_daddr(ins, a);
        if (ins[6:0] != 7'b0000011) return 1'b0;
        case (ins[14:12])
            3'b001, 3'b101: sz = 2;
            3'b010:         sz = 4;
            default:        sz = 1;
        endcase
        return (ad % sz) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_alu(input logic [31:0] ins, input logic [31:0] a);
        int          imm;
        int          sa;
        int          shamt;
        logic [31:0] r;
        imm   = imm12(ins);
        sa    = a;
        shamt = int'(ins[24:20]);
        case (ins[14:12])
            3'b000: r = a + imm;
            3'b010: r = (sa < imm) ? 32'd1 : 32'd0;
            3'b011: r = (a < 32'(imm)) ? 32'd1 : 32'd0;
            3'b100: r = a ^ imm;
            3'b110: r = a | imm;
            3'b111: r = a & imm;
            3'b001: r = a << shamt;
            default: r = ins[30] ? 32'(sa >>> shamt) : (a >> shamt);
        endcase
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] ins, input logic [31:0] a,
                                           input logic [31:0] dr);
        logic [31:0] ad;
        logic [31:0] bsh;
        logic [31:0] hsh;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        ad  = m_daddr(ins, a);
        bsh = dr >> (8 * ad[1:0]);
        hsh = dr >> (16 * ad[1]);
        sb  = bsh[7:0];
        sh  = hsh[15:0];
        if (m_misaligned(ins, a)) return 32'd0;
        case (ins[14:12])
            3'b000: return 32'(int'(sb));
            3'b001: return 32'(int'(sh));
            3'b010: return dr;
            3'b100: return bsh & 32'hFF;
            3'b101: return hsh & 32'hFFFF;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_taken(input logic [31:0] ins, input logic [31:0] a,
                                     input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (ins[6:0] != 7'b1100011) return 1'b0;
        case (ins[14:12])
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return sa < sb;
            3'b101: return sa >= sb;
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_illegal(input logic [31:0] ins, input logic [31:0] a);
        logic [2:0] f;
        f = ins[14:12];
        if (m_misaligned(ins, a)) return 1'b1;
        case (ins[6:0])
            7'b0010011: return (f == 3'b001 && ins[31:25] != 7'd0) ||
                               (f == 3'b101 && ins[31:25] != 7'd0 && ins[31:25] != 7'h20);
            7'b0000011: return f == 3'b011 || f == 3'b110 || f == 3'b111;
            7'b1100011: return f == 3'b010 || f == 3'b011;
            default:    return 1'b0;
        endcase
    endfunction

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(input logic [2:0] f, input logic [11:0] imm);
        return {imm, 5'd1, f, 5'd2, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_l(input logic [2:0] f, input logic [11:0] imm);
        return {imm, 5'd1, f, 5'd2, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // One transaction: drive, check combinational results, clock, check status.
    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] ia,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] dr,
                        input logic clr);
        logic        tk;
        logic [31:0] nxt;
        idata   = ins;
        iaddr   = ia;
        rv1     = a;
        rv2     = b;
        drdata  = dr;
        err_clr = clr;
        #1;
        tk  = m_taken(ins, a, b);
        nxt = tk ? ia + immb(ins) : ia + 32'd4;
        chk({tag, ".daddr"}, daddr, m_daddr(ins, a));
        chk({tag, ".regdata_I"}, regdata_I, m_alu(ins, a));
        if (ins[6:0] == 7'b0000011)
            chk({tag, ".regdata_L"}, regdata_L, m_load(ins, a, dr));
        chk({tag, ".br_taken"}, {31'd0, br_taken}, {31'd0, tk});
        chk({tag, ".iaddr_val"}, iaddr_val, nxt);
        @(posedge clk);
        if (clr) m_err = 1'b0;
        else if (m_illegal(ins, a)) m_err = 1'b1;
        if (tk) m_cnt = m_cnt + 16'd1;
        #1;
        chk({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
        chk({tag, ".br_cnt"}, {16'd0, br_cnt}, {16'd0, m_cnt});
        $display("[TB] %s idata=%h rv1=%h rv2=%h I=%h L=%h next=%h tk=%0b err=%0b cnt=%0d",
                 tag, ins, a, b, regdata_I, regdata_L, iaddr_val, br_taken, err, br_cnt);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        int          kind;

        reset   = 1'b0;
        idata   = 32'h0000_0013;
        iaddr   = 32'd0;
        rv1     = 32'd0;
        rv2     = 32'd0;
        drdata  = 32'd0;
        err_clr = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 16'd0;
        #3;
        chk("reset.err", {31'd0, err}, 32'd0);
        chk("reset.br_cnt", {16'd0, br_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // I class
        step("addi_ovf", enc_i(3'b000, 12'd1), 32'h0, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b0);
        chk("addi_ovf.const", regdata_I, 32'h8000_0000);
        step("srai4", enc_i(3'b101, {7'b0100000, 5'd4}), 32'h0, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
        chk("srai4.const", regdata_I, 32'hF800_0000);
        step("sltiu", enc_i(3'b011, 12'hFFF), 32'h0, 32'h1, 32'h0, 32'h0, 1'b0);
        chk("sltiu.const", regdata_I, 32'h1);

        // L class
        step("lb01", enc_l(3'b000, 12'd1), 32'h0, 32'h2000, 32'h0, 32'h8899AABB, 1'b0);
        chk("lb01.const", regdata_L, 32'hFFFF_FFAA);
        step("lbu01", enc_l(3'b100, 12'd1), 32'h0, 32'h2000, 32'h0, 32'h8899AABB, 1'b0);
        chk("lbu01.const", regdata_L, 32'h0000_00AA);
        step("lh10", enc_l(3'b001, 12'd2), 32'h0, 32'h2000, 32'h0, 32'h8899AABB, 1'b0);
        chk("lh10.const", regdata_L, 32'hFFFF_8899);
        step("lw", enc_l(3'b010, 12'd0), 32'h0, 32'h2000, 32'h0, 32'h8899AABB, 1'b0);
        chk("lw.const", regdata_L, 32'h8899_AABB);

        // B class
        step("blt", enc_b(3'b100, 13'h1FF8), 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        chk("blt.taken", {31'd0, br_taken}, 32'd1);
        chk("blt.next", iaddr_val, 32'h0000_00F8);
        step("bltu", enc_b(3'b110, 13'h1FF8), 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        chk("bltu.taken", {31'd0, br_taken}, 32'd0);
        chk("bltu.next", iaddr_val, 32'h0000_0104);

        // Counter: blt above took one branch, three more BEQs follow
        for (int i = 0; i < 3; i++)
            step("beq", enc_b(3'b000, 13'd16), 32'h200, 32'h55, 32'h55, 32'h0, 1'b0);
        chk("beq3.cnt", {16'd0, br_cnt}, 32'd4);

        // err flag
        step("ld_f3_011", enc_l(3'b011, 12'd0), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("ld_f3_011.err", {31'd0, err}, 32'd1);
        step("legal_after", enc_i(3'b000, 12'd5), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("legal_after.err", {31'd0, err}, 32'd1);
        step("clr_vs_ill", enc_b(3'b010, 13'd8), 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("clr_vs_ill.err", {31'd0, err}, 32'd0);

        // Misaligned LW at 0x1002
        step("lw_mis", enc_l(3'b010, 12'd2), 32'h0, 32'h1000, 32'h0, 32'hCAFE_F00D, 1'b0);
`ifdef RV_BIL_MISALIGN_CHK_EN
        chk("lw_mis.err", {31'd0, err}, 32'd1);
        chk("lw_mis.L", regdata_L, 32'd0);
`else
        chk("lw_mis.err", {31'd0, err}, 32'd0);
        chk("lw_mis.L", regdata_L, 32'hCAFE_F00D);
`endif

        // Randomized instructions
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 3));
            ins  = $urandom;
            case (kind)
                0: ins[6:0] = 7'b0010011;
                1: ins[6:0] = 7'b0000011;
                2: ins[6:0] = 7'b1100011;
                default: ;
            endcase
            if (kind == 0 && $urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            step("rand", ins, $urandom, a, b, $urandom, ($urandom_range(0, 7) == 0));
        end

        // Make sure there is state to clear, then reset mid-cycle
        step("pre_rst", enc_b(3'b011, 13'd4), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step("pre_rst2", enc_b(3'b000, 13'd4), 32'h0, 32'h7, 32'h7, 32'h0, 1'b0);
        #2;
        reset = 1'b0;
        m_err = 1'b0;
        m_cnt = 16'd0;
        #1;
        chk("midrst.err", {31'd0, err}, 32'd0);
        chk("midrst.br_cnt", {16'd0, br_cnt}, 32'd0);
        $display("[TB] midrst err=%0b cnt=%0d", err, br_cnt);
        @(negedge clk);
        reset = 1'b1;
        step("post_rst", enc_b(3'b001, 13'd12), 32'h40, 32'h1, 32'h2, 32'h0, 1'b0);
        chk("post_rst.cnt", {16'd0, br_cnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rv32_bil_exec_unit.md
Name: rv32_bil_exec_unit

Overview:
- Combined RV32I datapath slice for the three opcode classes the CPU core dispatches to helper units.
  - Branch class (B): compare and next-PC generation.
  - Register-immediate ALU class (I): ALU result.
  - Load class (L): address generation and load-data extraction/extension.
- Result paths are combinational and feed the core's write-back and PC muxes in the same cycle.
- A small clocked status block holds a sticky illegal-encoding flag and a branch-taken counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 16, width of the branch-taken counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- idata  in  32  current instruction word.
- iaddr  in  32  PC of the current instruction.
- rv1  in  32  rs1 register value.
- rv2  in  32  rs2 register value.
- drdata  in  32  word read from data memory at {daddr[31:2],2'b00}.
- err_clr  in  1  synchronous clear of the sticky error flag.
- daddr  out  32  load address, rv1 + sign-extended imm[11:0].
- regdata_I  out  32  I-class ALU result.
- regdata_L  out  32  extended load result.
- iaddr_val  out  32  next PC for the B class.
- br_taken  out  1  branch condition true (B opcode only).
- err  out  1  sticky illegal-encoding flag.
- br_cnt  out  CNT_W  count of taken branches.

Behaviour:
- Decode: opcode = idata[6:0], f3 = idata[14:12].
  - I class: 0010011. L class: 0000011. B class: 1100011.
- Immediates:
  - I/L: sign-extend idata[31:20].
  - B: sign-extend {idata[31], idata[7], idata[30:25], idata[11:8], 1'b0}.
- I class, by f3:
  - 000 ADDI: rv1 + imm, wrap mod 2^32.
  - 010 SLTI: signed compare, result 1 or 0.
  - 011 SLTIU: unsigned compare, result 1 or 0.
  - 100 XORI; 110 ORI; 111 ANDI.
  - 001 SLLI: shamt = idata[24:20].
  - 101: SRAI when idata[30]=1, else SRLI.
  - regdata_I is computed from the fields every cycle regardless of opcode.
- L class:
  - Load address: daddr = rv1 + imm.
  - Byte select by daddr[1:0]; halfword select by daddr[1].
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected halfword.
  - 010 LW: drdata unchanged.
  - 100 LBU / 101 LHU: zero-extend.
  - Any other f3: regdata_L = 0.
- B class, by f3:
  - 000 BEQ; 001 BNE.
  - 100 BLT; 101 BGE (signed).
  - 110 BLTU; 111 BGEU (unsigned).
  - Illegal f3 (010, 011): not taken.
  - br_taken = 0 whenever the opcode is not B.
  - iaddr_val = br_taken ? iaddr + Bimm : iaddr + 4, wrap mod 2^32.
- Illegal encodings:
  - I class: f3=001 with idata[31:25] != 0; f3=101 with idata[31:25] not in {0000000, 0100000}.
  - L class: f3 in {011, 110, 111}.
  - B class: f3 in {010, 011}.
- err:
  - Cleared to 0 asynchronously while reset = 0.
  - On a clk edge, err_clr=1 clears it. Otherwise it is set to 1 if the current instruction is illegal. Otherwise it holds.
  - Clear wins over a simultaneous set.
- br_cnt:
  - Reset value 0.
  - Increments on each clk edge where br_taken = 1; wraps from all-ones to 0.
- Reset does not affect the combinational outputs.
- Latency: 0 cycles for all result outputs; 1 cycle for err and br_cnt.

Optional Feature:
- Macro: RV_BIL_MISALIGN_CHK_EN.
- Defined:
  - L class with f3 in {001, 101} and daddr[0]=1 is illegal.
  - L class with f3 = 010 and daddr[1:0] != 00 is illegal.
  - A misaligned load sets err and forces regdata_L = 0.
- Not defined: misaligned loads use the select rules above and never set err.

Test Plan:
- I class:
  - ADDI x, rv1=0x7FFFFFFF, imm=1 -> regdata_I = 0x80000000.
  - SRAI shamt 4, rv1=0x80000000 -> 0xF8000000.
  - SLTIU rv1=1, imm=-1 -> 1.
- L class:
  - drdata=0x8899AABB, LB with daddr[1:0]=01 -> 0xFFFFFFAA.
  - LBU same address -> 0x000000AA.
  - LH with daddr[1]=1 -> 0xFFFF8899.
  - LW -> 0x8899AABB.
- B class:
  - BLT rv1=0xFFFFFFFF, rv2=1, iaddr=0x100, imm=-8 -> br_taken=1, iaddr_val=0xF8.
  - BLTU same operands -> br_taken=0, iaddr_val=0x104.
- Counter:
  - 3 consecutive taken BEQ -> br_cnt = 3.
  - Assert reset low mid-cycle -> br_cnt and err read 0 immediately, without waiting for a clock edge.
- err flag:
  - Load f3=011 -> err=1 after the next edge; stays 1 on following legal instructions.
  - err_clr=1 together with an illegal instruction -> err=0.
- Feature build (RV_BIL_MISALIGN_CHK_EN defined):
  - LW at daddr=0x1002 -> err=1, regdata_L=0.
  - Same stimulus without the macro -> err=0, regdata_L=drdata.
